// File: rtl/dcache_burst.sv
`default_nettype none
// ============================================================================
// Module   : dcache_burst
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache with
//            multi-word lines refilled one beat at a time. Supports
//            byte-strobed stores, single-cycle invalidate-all (flush) and
//            free-running read hit/miss counters. One memory transaction at
//            a time, sequenced by a four-state FSM.
// Ports    : clk, reset (async, active-low)
//            core side  : read_request, write_request, flush, addr,
//                         write_data, write_strobe -> response, read_data
//            memory side: memory_read_request, memory_write_request,
//                         memory_addr, memory_write_data,
//                         memory_write_strobe <- memory_response,
//                         memory_read_data
//            statistics : hit_count, miss_count
// Revision : 1.0 - multi-word line cache with burst refill
// ============================================================================
module dcache_burst #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_request,
  input  logic        write_request,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic        response,
  output logic [31:0] read_data,
  output logic        memory_read_request,
  output logic        memory_write_request,
  input  logic        memory_response,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_write_data,
  output logic [3:0]  memory_write_strobe,
  input  logic [31:0] memory_read_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int C_OFF_W = $clog2(LINE_WORDS);
  localparam int C_IDX_W = $clog2(NUM_LINES);
  localparam int C_TAG_W = 30 - C_OFF_W - C_IDX_W;
  localparam int C_WORDS = NUM_LINES * LINE_WORDS;
  localparam logic [C_OFF_W-1:0] C_LAST_BEAT = C_OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [C_OFF_W-1:0]    r_beat;
  logic [NUM_LINES-1:0]  r_valid;
  logic [31:0]           r_read_data;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;
  logic [C_TAG_W-1:0]    r_tag_mem  [NUM_LINES];
  logic [31:0]           r_data_mem [C_WORDS];

  // --------------------------------------------------------------------------
  // Address decode and lookup
  // --------------------------------------------------------------------------
  logic [C_OFF_W-1:0]          w_off;
  logic [C_IDX_W-1:0]          w_idx;
  logic [C_TAG_W-1:0]          w_tag;
  logic [C_IDX_W+C_OFF_W-1:0]  w_word_sel;
  logic [C_IDX_W+C_OFF_W-1:0]  w_refill_sel;
  logic [31:0]                 w_cached_word;
  logic [31:0]                 w_merged;
  logic                        w_hit;
  logic                        w_in_idle;
  logic                        w_do_write;
  logic                        w_do_read;
  logic                        w_refill_beat;
  logic                        w_unused;

  assign w_off = addr[C_OFF_W+1:2];
  assign w_idx = addr[C_OFF_W+C_IDX_W+1:C_OFF_W+2];
  assign w_tag = addr[31:C_OFF_W+C_IDX_W+2];

  // Byte offset within the word plays no part in the lookup.
  assign w_unused = &{1'b0, addr[1:0]};

  assign w_word_sel    = {w_idx, w_off};
  assign w_refill_sel  = {w_idx, r_beat};
  assign w_cached_word = r_data_mem[w_word_sel];
  assign w_hit         = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

  // Flush outranks stores, stores outrank loads.
  assign w_in_idle     = (r_state == ST_IDLE);
  assign w_do_write    = w_in_idle && !flush && write_request;
  assign w_do_read     = w_in_idle && !flush && !write_request && read_request;
  assign w_refill_beat = (r_state == ST_REFILL) && memory_response;

  // Store data merged byte-wise into the currently cached word.
  always_comb begin
    w_merged = w_cached_word;
    for (int b = 0; b < 4; b++) begin
      if (write_strobe[b]) begin
        w_merged[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data and tag arrays (no reset; validity is tracked by r_valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_do_write && w_hit) begin
        r_data_mem[w_word_sel] <= w_merged;
      end
      if (w_refill_beat) begin
        r_data_mem[w_refill_sel] <= memory_read_data;
      end
      // The tag is written at miss time; the line stays invalid until the
      // last beat lands, so a partially refilled line can never hit.
      if (w_do_read && !w_hit) begin
        r_tag_mem[w_idx] <= w_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM, valid bits, load data and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_valid      <= '0;
      r_read_data  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (write_request) begin
            r_state <= ST_WRITE;
          end else if (read_request) begin
            if (w_hit) begin
              r_read_data <= w_cached_word;
              r_hit_count <= r_hit_count + 32'd1;
              r_state     <= ST_RESP;
            end else begin
              r_miss_count   <= r_miss_count + 32'd1;
              r_valid[w_idx] <= 1'b0;
              r_beat         <= '0;
              r_state        <= ST_REFILL;
            end
          end
        end

        ST_REFILL: begin
          if (memory_response) begin
            // The requested word is captured as it streams past.
            if (r_beat == w_off) begin
              r_read_data <= memory_read_data;
            end
            if (r_beat == C_LAST_BEAT) begin
              r_valid[w_idx] <= 1'b1;
              r_state        <= ST_RESP;
            end else begin
              r_beat <= r_beat + C_OFF_W'(1);
            end
          end
        end

        ST_WRITE: begin
          if (memory_response) begin
            r_state <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they drop to zero the
  // moment reset forces the FSM back to IDLE.
  // --------------------------------------------------------------------------
  assign response             = (r_state == ST_RESP);
  assign read_data            = r_read_data;
  assign hit_count            = r_hit_count;
  assign miss_count           = r_miss_count;
  assign memory_read_request  = (r_state == ST_REFILL);
  assign memory_write_request = (r_state == ST_WRITE);

  always_comb begin
    memory_addr         = 32'd0;
    memory_write_data   = 32'd0;
    memory_write_strobe = 4'd0;
    if (r_state == ST_REFILL) begin
      memory_addr = {w_tag, w_idx, r_beat, 2'b00};
    end else if (r_state == ST_WRITE) begin
      memory_addr         = {addr[31:2], 2'b00};
      memory_write_data   = write_data;
      memory_write_strobe = write_strobe;
    end
  end

endmodule
`default_nettype wire

// File: doc/dcache_burst.md
# dcache_burst

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's load/store unit and the memory port. It supersedes the one-word-per-entry cache with configurable multi-word lines and sequential beat refill. It adds byte-strobed stores, a single-cycle invalidate-all, and hit/miss counters. All responses are registered, and an explicit FSM serialises every memory transaction.

## Interface
- NUM_LINES, 16: number of lines; power of two, 2..256.
- LINE_WORDS, 4: 32-bit words per line; power of two, 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; one clock, asynchronous, active-low.
- read_request  in  1  load request; level, held until response.
- write_request  in  1  store request; level, held until response.
- flush  in  1  invalidate all lines; sampled only in IDLE.
- addr  in  32  byte address; held stable while a request is high.
- write_data  in  32  store data.
- write_strobe  in  4  byte enables for the store; bit i selects write_data[8i+7:8i].
- response  out  1  one-cycle completion pulse.
- read_data  out  32  load data; valid when response=1, held until the next response.
- memory_read_request  out  1  word read to memory.
- memory_write_request  out  1  word write to memory.
- memory_response  in  1  one-cycle memory completion pulse.
- memory_addr  out  32  word-aligned memory address.
- memory_write_data  out  32  store data to memory.
- memory_write_strobe  out  4  byte enables to memory.
- memory_read_data  in  32  memory data; valid with memory_response.
- hit_count  out  32  count of read hits; wraps.
- miss_count  out  32  count of read misses; wraps.

## Operation
- Address split: OFF = log2(LINE_WORDS) bits at addr[OFF+1:2]. IDX = log2(NUM_LINES) bits above those. TAG = 30 − OFF − IDX bits at the top. addr[1:0] is ignored for lookup.
- Storage: a data array of NUM_LINES×LINE_WORDS words, a tag array, and a NUM_LINES-bit valid vector.
- FSM states: IDLE, REFILL, WRITE, RESP.
- IDLE, flush=1: clear all valid bits in one edge. Flush has priority over requests. No response is generated, and the state stays IDLE.
- IDLE, write_request=1: go to WRITE. write_request has priority if read_request is also high; the read is ignored.
  - On a write hit, merge the strobed bytes into the cached word on the same edge.
  - On a write miss, the cache is unchanged.
- IDLE, read hit: latch the word into read_data, increment hit_count, go to RESP.
- IDLE, read miss: increment miss_count, clear valid[IDX], write the tag, set beat counter = 0, go to REFILL.
- REFILL:
  - memory_read_request=1 and memory_addr = {tag, IDX, beat, 2'b00}.
  - On memory_response: store the word at [IDX][beat]. If beat equals the requested offset, latch the word into read_data.
  - If beat = LINE_WORDS−1: set valid[IDX] and go to RESP. Otherwise beat+1, with the request kept high and the address updating on the next cycle.
- WRITE: memory_write_request=1, with memory_addr = {addr[31:2], 2'b00} and write_data/strobe passed through. On memory_response go to RESP.
- RESP: response=1 for exactly one cycle, then IDLE.
- All memory_* outputs are 0 when not in REFILL or WRITE, respectively.

## Timing
- Reset (asynchronous assert):
  - State → IDLE; all valid bits cleared; beat counter 0.
  - response, read_data, hit_count, miss_count and all memory_* outputs go to 0 immediately.
  - Any in-flight refill or write is abandoned. A late memory_response in IDLE is ignored.
- Read hit: request sampled at edge N; response and read_data at N+1; IDLE at N+2.
- Read miss: response arrives one cycle after the LINE_WORDS-th memory_response.
- Store: response arrives one cycle after memory_response.
- Back-to-back: the core must drop its request on the edge at which it samples response=1. The minimum request-to-request spacing is one idle cycle.
- Address or strobe changes while a request is high: undefined. The bench must not do this.
- Memory responding in the same cycle as the request is legal. memory_response outside REFILL/WRITE is ignored.
- Counters wrap from 0xFFFFFFFF to 0 with no flag.
- flush during REFILL/WRITE is ignored; it must be held until IDLE to take effect.

## Test plan
- Reset, then read 0x100 (NUM_LINES=16, LINE_WORDS=4) → 4 beats at 0x100, 0x104, 0x108, 0x10C. response after beat 4, read_data = word of 0x100, miss_count=1.
- Read 0x10C after that refill → response one cycle after request, no memory traffic, hit_count=1.
- Store 0xAABBCCDD to 0x104 with strobe 4'b0011, where 0x104 held 0x11223344 → memory write with strobe 0011. A subsequent read of 0x104 hits and returns 0x1122CCDD.
- Store to an uncached address 0x2000, then read 0x2000 → the store produces no allocation; the read misses and refills 0x2000..0x200C.
- Fill line 0 via 0x000, then read 0x400 (same index, different tag) → the line is replaced. A following read of 0x000 misses.
- Assert flush in IDLE, then read a previously cached address → miss with refill. Separately, assert reset after beat 2 of a refill → outputs go to 0 at once, and the line is invalid afterwards.
